// File: rtl/alu_exec_seq_if.sv
// Request / ALU / response bundle for the alu_exec_seq execute sequencer.
// RSP_MISALIGN exists only when ALU_EXEC_SEQ_MISALIGN_EN is defined.
interface alu_exec_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            REQ_VALID;
    logic            REQ_READY;
    logic [1:0]      REQ_KIND;
    logic [3:0]      REQ_CTRL;
    logic [2:0]      REQ_COND;
    logic [XLEN-1:0] REQ_A;
    logic [XLEN-1:0] REQ_B;
    logic [XLEN-1:0] REQ_PC;
    logic [XLEN-1:0] REQ_IMM;
    logic [XLEN-1:0] ALU_A;
    logic [XLEN-1:0] ALU_B;
    logic [3:0]      ALU_CTRL;
    logic [XLEN-1:0] ALU_OUT;
    logic            RSP_VALID;
    logic            RSP_READY;
    logic [XLEN-1:0] RSP_RESULT;
    logic            RSP_TAKEN;
    logic [XLEN-1:0] RSP_TARGET;
`ifdef ALU_EXEC_SEQ_MISALIGN_EN
    logic            RSP_MISALIGN;
`endif

    modport master (
        output REQ_VALID, REQ_KIND, REQ_CTRL, REQ_COND, REQ_A, REQ_B, REQ_PC, REQ_IMM,
        input  REQ_READY,
        input  ALU_A, ALU_B, ALU_CTRL,
        output ALU_OUT,
        input  RSP_VALID, RSP_RESULT, RSP_TAKEN, RSP_TARGET,
`ifdef ALU_EXEC_SEQ_MISALIGN_EN
        input  RSP_MISALIGN,
`endif
        output RSP_READY
    );

    modport slave (
        input  REQ_VALID, REQ_KIND, REQ_CTRL, REQ_COND, REQ_A, REQ_B, REQ_PC, REQ_IMM,
        output REQ_READY,
        output ALU_A, ALU_B, ALU_CTRL,
        input  ALU_OUT,
        output RSP_VALID, RSP_RESULT, RSP_TAKEN, RSP_TARGET,
`ifdef ALU_EXEC_SEQ_MISALIGN_EN
        output RSP_MISALIGN,
`endif
        input  RSP_READY
    );
endinterface

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer sharing one external ALU for ALU ops, branches and JAL.
// Optional misaligned-target flag enabled by defining ALU_EXEC_SEQ_MISALIGN_EN.
module alu_exec_seq #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] LINK_INC = XLEN'(4)
) (
    input  logic          CLK,
    input  logic          RST_N,
    alu_exec_seq_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_OP, S_CMP, S_TGT, S_LINK, S_DONE} state_e;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    state_e          state_q, state_d;
    logic [1:0]      kind_q, kind_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [2:0]      cond_q, cond_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, pc_q, pc_d, imm_q, imm_d;
    logic            valid_q, valid_d, taken_q, taken_d, mis_q, mis_d;
    logic [XLEN-1:0] result_q, result_d, target_q, target_d;
    logic            op_legal, op_shift;

    assign op_legal = (ctrl_q <= OP_SLTU);
    assign op_shift = (ctrl_q >= OP_SLL) && (ctrl_q <= OP_SRA);

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        ctrl_d       = ctrl_q;
        cond_d       = cond_q;
        a_d          = a_q;
        b_d          = b_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        valid_d      = valid_q;
        taken_d      = taken_q;
        result_d     = result_q;
        target_d     = target_q;
        mis_d        = mis_q;
        bus.ALU_A    = '0;
        bus.ALU_B    = '0;
        bus.ALU_CTRL = OP_ADD;
        unique case (state_q)
            S_IDLE: begin
                if (bus.REQ_VALID) begin
                    kind_d   = bus.REQ_KIND;
                    ctrl_d   = bus.REQ_CTRL;
                    cond_d   = bus.REQ_COND;
                    a_d      = bus.REQ_A;
                    b_d      = bus.REQ_B;
                    pc_d     = bus.REQ_PC;
                    imm_d    = bus.REQ_IMM;
                    taken_d  = 1'b0;
                    result_d = '0;
                    target_d = '0;
                    mis_d    = 1'b0;
                    unique case (bus.REQ_KIND)
                        2'b01:   state_d = S_CMP;
                        2'b10:   state_d = S_TGT;
                        default: state_d = S_OP;
                    endcase
                end
            end
            S_OP: begin
                // Undefined opcodes run a harmless ADD but report a zero result.
                bus.ALU_CTRL = op_legal ? ctrl_q : OP_ADD;
                bus.ALU_A    = a_q;
                bus.ALU_B    = op_shift ? {{(XLEN-5){1'b0}}, b_q[4:0]} : b_q;
                result_d     = op_legal ? bus.ALU_OUT : '0;
                valid_d      = 1'b1;
                state_d      = S_DONE;
            end
            S_CMP: begin
                bus.ALU_A    = a_q;
                bus.ALU_B    = b_q;
                bus.ALU_CTRL = !cond_q[2] ? OP_SUB : (cond_q[1] ? OP_SLTU : OP_SLT);
                unique case (cond_q)
                    3'b000:        taken_d = (bus.ALU_OUT == '0);
                    3'b001:        taken_d = (bus.ALU_OUT != '0);
                    3'b100, 3'b110: taken_d = bus.ALU_OUT[0];
                    3'b101, 3'b111: taken_d = !bus.ALU_OUT[0];
                    default:       taken_d = 1'b0;
                endcase
                state_d = S_TGT;
            end
            S_TGT: begin
                bus.ALU_B = imm_q;
                if (kind_q == 2'b10) begin
                    bus.ALU_A = a_q;
                    target_d  = bus.ALU_OUT & {{(XLEN-1){1'b1}}, 1'b0};
                    taken_d   = 1'b1;
                    state_d   = S_LINK;
                end else begin
                    bus.ALU_A = pc_q;
                    target_d  = bus.ALU_OUT;
                    valid_d   = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_LINK: begin
                bus.ALU_A = pc_q;
                bus.ALU_B = LINK_INC;
                result_d  = bus.ALU_OUT;
                valid_d   = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (bus.RSP_READY) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef ALU_EXEC_SEQ_MISALIGN_EN
        if (state_d == S_DONE && state_q != S_DONE) mis_d = taken_d && (target_d[1:0] != 2'b00);
`else
        mis_d = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            kind_q   <= '0;
            ctrl_q   <= '0;
            cond_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            result_q <= '0;
            target_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            ctrl_q   <= ctrl_d;
            cond_q   <= cond_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            valid_q  <= valid_d;
            taken_q  <= taken_d;
            result_q <= result_d;
            target_q <= target_d;
            mis_q    <= mis_d;
        end
    end

    assign bus.REQ_READY  = (state_q == S_IDLE);
    assign bus.RSP_VALID  = valid_q;
    assign bus.RSP_RESULT = result_q;
    assign bus.RSP_TAKEN  = taken_q;
    assign bus.RSP_TARGET = target_q;
`ifdef ALU_EXEC_SEQ_MISALIGN_EN
    assign bus.RSP_MISALIGN = mis_q;
`else
    logic unused_mis;
    assign unused_mis = mis_q;
`endif
endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed testbench for alu_exec_seq with a behavioural ALU on the shared ALU port.
// Checks RSP_MISALIGN as well when ALU_EXEC_SEQ_MISALIGN_EN is defined.
module tb_alu_exec_seq;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    alu_exec_seq_if #(.XLEN(32)) bif ();

    alu_exec_seq #(.XLEN(32), .LINK_INC(32'd4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bif)
    );

    always #5 CLK = ~CLK;

    // Unmasked shift distance: the sequencer is responsible for masking it.
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b;
            4'd3:    return a >> b;
            4'd4:    return $signed(a) >>> b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return {31'b0, $signed(a) < $signed(b)};
            4'd9:    return {31'b0, a < b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb bif.ALU_OUT = alu_f(bif.ALU_CTRL, bif.ALU_A, bif.ALU_B);

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] kind, input logic [3:0] ctrl,
                         input logic [2:0] cond, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm);
        for (int i = 0; i < 20 && !bif.REQ_READY; i++) step();
        chk({tag, "/req_ready"}, {31'b0, bif.REQ_READY}, 32'd1);
        bif.REQ_VALID = 1'b1;
        bif.REQ_KIND  = kind;
        bif.REQ_CTRL  = ctrl;
        bif.REQ_COND  = cond;
        bif.REQ_A     = a;
        bif.REQ_B     = b;
        bif.REQ_PC    = pc;
        bif.REQ_IMM   = imm;
        step();
        // Scribble on the request after accept; it must be ignored.
        bif.REQ_VALID = 1'b0;
        bif.REQ_KIND  = 2'b01;
        bif.REQ_A     = 32'h5A5A_5A5A;
        bif.REQ_B     = 32'hA5A5_A5A5;
        bif.REQ_PC    = 32'h0BAD_0000;
        bif.REQ_IMM   = 32'h0000_0FFF;
    endtask

    task automatic expect_rsp(input string tag, input int exp_wait, input logic [31:0] res,
                              input logic tk, input logic [31:0] tgt, input logic mis);
        int n = 0;
        while (!bif.RSP_VALID && n < 10) begin
            step();
            n++;
        end
        chk({tag, "/latency"}, n, exp_wait);
        chk({tag, "/result"}, bif.RSP_RESULT, res);
        chk({tag, "/taken"}, {31'b0, bif.RSP_TAKEN}, {31'b0, tk});
        chk({tag, "/target"}, bif.RSP_TARGET, tgt);
        chk({tag, "/busy"}, {31'b0, bif.REQ_READY}, 32'd0);
`ifdef ALU_EXEC_SEQ_MISALIGN_EN
        chk({tag, "/misalign"}, {31'b0, bif.RSP_MISALIGN}, {31'b0, mis});
`else
        if (mis) n = n;
`endif
        if (bif.RSP_READY) begin
            step();
            chk({tag, "/idle"}, {31'b0, bif.REQ_READY, bif.RSP_VALID}, 32'b10);
        end
    endtask

    initial begin
        logic [31:0] held;
        int          seen;
        bif.REQ_VALID = 1'b0;
        bif.REQ_KIND  = '0;
        bif.REQ_CTRL  = '0;
        bif.REQ_COND  = '0;
        bif.REQ_A     = '0;
        bif.REQ_B     = '0;
        bif.REQ_PC    = '0;
        bif.REQ_IMM   = '0;
        bif.RSP_READY = 1'b1;
        repeat (3) step();
        chk("rst/valid", {31'b0, bif.RSP_VALID}, 32'd0);
        chk("rst/result", bif.RSP_RESULT, 32'd0);
        chk("rst/target", bif.RSP_TARGET, 32'd0);
        chk("rst/taken", {31'b0, bif.RSP_TAKEN}, 32'd0);
        chk("rst/alu", {bif.ALU_CTRL, bif.ALU_A[27:0] | bif.ALU_B[27:0]}, 32'd0);
        RST_N = 1'b1;
        step();
        chk("rst/ready", {31'b0, bif.REQ_READY}, 32'd1);

        // ALU ops (kind 00 and 11)
        issue("add", 2'b00, 4'd0, 3'd0, 32'd5, 32'd7, 32'h100, 32'h20);
        chk("add/not_yet", {31'b0, bif.RSP_VALID}, 32'd0);
        expect_rsp("add", 1, 32'd12, 1'b0, 32'd0, 1'b0);
        issue("sll", 2'b00, 4'd2, 3'd0, 32'd1, 32'h21, 32'h0, 32'h0);
        expect_rsp("sll", 1, 32'd2, 1'b0, 32'd0, 1'b0);
        issue("sra", 2'b00, 4'd4, 3'd0, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
        expect_rsp("sra", 1, 32'hF800_0000, 1'b0, 32'd0, 1'b0);
        issue("sub", 2'b00, 4'd1, 3'd0, 32'd3, 32'd5, 32'h0, 32'h0);
        expect_rsp("sub", 1, 32'hFFFF_FFFE, 1'b0, 32'd0, 1'b0);
        issue("slt", 2'b00, 4'd8, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        expect_rsp("slt", 1, 32'd1, 1'b0, 32'd0, 1'b0);
        issue("sltu", 2'b00, 4'd9, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        expect_rsp("sltu", 1, 32'd0, 1'b0, 32'd0, 1'b0);
        issue("badop", 2'b00, 4'hC, 3'd0, 32'd5, 32'd7, 32'h0, 32'h0);
        expect_rsp("badop", 1, 32'd0, 1'b0, 32'd0, 1'b0);
        issue("kind11", 2'b11, 4'd0, 3'd0, 32'd2, 32'd3, 32'h0, 32'h0);
        expect_rsp("kind11", 1, 32'd5, 1'b0, 32'd0, 1'b0);

        // Branches
        issue("beq", 2'b01, 4'd0, 3'b000, 32'h10, 32'h10, 32'h100, 32'h20);
        expect_rsp("beq", 2, 32'd0, 1'b1, 32'h120, 1'b0);
        issue("bne", 2'b01, 4'd0, 3'b001, 32'h10, 32'h10, 32'h100, 32'h20);
        expect_rsp("bne", 2, 32'd0, 1'b0, 32'h120, 1'b0);
        issue("bltu", 2'b01, 4'd0, 3'b110, 32'd1, 32'hFFFF_FFFF, 32'h100, 32'h20);
        expect_rsp("bltu", 2, 32'd0, 1'b1, 32'h120, 1'b0);
        issue("bge", 2'b01, 4'd0, 3'b101, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'h20);
        expect_rsp("bge", 2, 32'd0, 1'b0, 32'h120, 1'b0);
        issue("blt", 2'b01, 4'd0, 3'b100, 32'hFFFF_FFFE, 32'd1, 32'h100, 32'hFFFF_FFF0);
        expect_rsp("blt", 2, 32'd0, 1'b1, 32'hF0, 1'b0);
        issue("bgeu", 2'b01, 4'd0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h22);
        expect_rsp("bgeu", 2, 32'd0, 1'b1, 32'h122, 1'b1);
        issue("cond010", 2'b01, 4'd0, 3'b010, 32'h10, 32'h10, 32'h100, 32'h20);
        expect_rsp("cond010", 2, 32'd0, 1'b0, 32'h120, 1'b0);

        // Jumps
        issue("jal", 2'b10, 4'd0, 3'd0, 32'h1003, 32'h0, 32'h200, 32'd4);
        expect_rsp("jal", 2, 32'h204, 1'b1, 32'h1006, 1'b1);
        issue("jalwrap", 2'b10, 4'd0, 3'd0, 32'h10, 32'h0, 32'hFFFF_FFFC, 32'd0);
        expect_rsp("jalwrap", 2, 32'h0, 1'b1, 32'h10, 1'b0);

        // Backpressure: response must hold while RSP_READY is low
        bif.RSP_READY = 1'b0;
        issue("bp", 2'b00, 4'd7, 3'd0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0, 32'h0);
        expect_rsp("bp", 1, 32'h0000_FF00, 1'b0, 32'd0, 1'b0);
        held = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            held = held | (bif.RSP_RESULT ^ 32'h0000_FF00) | {30'b0, bif.REQ_READY, !bif.RSP_VALID};
        end
        chk("bp/stable", held, 32'd0);
        bif.RSP_READY = 1'b1;
        step();
        chk("bp/release", {31'b0, bif.REQ_READY, bif.RSP_VALID}, 32'b10);
        issue("bp_next", 2'b00, 4'd6, 3'd0, 32'd1, 32'd2, 32'h0, 32'h0);
        expect_rsp("bp_next", 1, 32'd3, 1'b0, 32'd0, 1'b0);

        // Reset while in CMP discards the branch
        issue("rstmid", 2'b01, 4'd0, 3'b000, 32'h10, 32'h10, 32'h100, 32'h20);
        RST_N = 1'b0;
        step();
        chk("rstmid/valid", {31'b0, bif.RSP_VALID}, 32'd0);
        chk("rstmid/ready", {31'b0, bif.REQ_READY}, 32'd1);
        chk("rstmid/outs", bif.RSP_RESULT | bif.RSP_TARGET | {31'b0, bif.RSP_TAKEN}, 32'd0);
        chk("rstmid/alu", {28'b0, bif.ALU_CTRL} | bif.ALU_A | bif.ALU_B, 32'd0);
        RST_N = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bif.RSP_VALID) seen++;
        end
        chk("rstmid/no_rsp", seen, 32'd0);
        issue("after_rst", 2'b00, 4'd5, 3'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 32'h0);
        expect_rsp("after_rst", 1, 32'h0F00_0F00, 1'b0, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
